// File: rtl/clk_tick_meter.sv
// clk_tick_meter: brings a slow (possibly asynchronous) wave into the clk
// domain, strobes its rising and falling edges, counts rising edges while
// enabled and measures the rise-to-rise interval in clk cycles.
//
// state   | meaning
// IDLE    | en low; interval counter held at 0, period/period_sat keep last value
// ARMED   | enabled, waiting for the first rise to start an interval
// MEASURE | interval counter running; every rise publishes a new period
module clk_tick_meter #(
  parameter int SYNC_STAGES = 2,   // 2..3
  parameter int CNT_W       = 16,
  parameter int PER_W       = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_in,
  input  logic             en,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] tick_cnt,
  output logic [PER_W-1:0] period,
  output logic             period_valid,
  output logic             period_sat
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } state_e;

  localparam logic [PER_W-1:0] PER_MAX = {PER_W{1'b1}};
  localparam logic [PER_W-1:0] PER_ONE = {{(PER_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   sync_s;
  logic                   rise_d;
  logic                   fall_d;

  state_e                 state_q;
  logic [PER_W-1:0]       ivl_q;
  logic [PER_W-1:0]       period_q;
  logic                   sat_q;
  logic                   valid_q;
  logic [CNT_W-1:0]       tick_q;

  // rise_d/fall_d are the internal edge events; the FSM acts on them in the
  // same cycle they are registered into rise_q/fall_q, so period_valid lines
  // up with rise_pulse.
  assign sync_s = sync_q[SYNC_STAGES-1];
  assign rise_d = sync_s & ~prev_q;
  assign fall_d = ~sync_s & prev_q;

  // Synchroniser chain, edge history flop and registered edge strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], div_in};
      prev_q <= sync_s;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  // Measurement FSM with edge counter, interval counter and period capture.
  // en low wins over a coincident rise: no count, no period that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ivl_q    <= '0;
      period_q <= '0;
      sat_q    <= 1'b0;
      valid_q  <= 1'b0;
      tick_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      if (en && rise_d) begin
        tick_q <= tick_q + CNT_ONE;
      end
      if (!en) begin
        state_q <= IDLE;
        ivl_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= ARMED;
          end
          ARMED: begin
            if (rise_d) begin
              ivl_q   <= PER_ONE;
              state_q <= MEASURE;
            end
          end
          MEASURE: begin
            if (rise_d) begin
              period_q <= ivl_q;
              sat_q    <= (ivl_q == PER_MAX);
              valid_q  <= 1'b1;
              ivl_q    <= PER_ONE;
            end else if (ivl_q != PER_MAX) begin
              ivl_q <= ivl_q + PER_ONE;
            end
          end
          default: begin
            state_q <= IDLE;
            ivl_q   <= '0;
          end
        endcase
      end
    end
  end

  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;
  assign tick_cnt     = tick_q;
  assign period       = period_q;
  assign period_valid = valid_q;
  assign period_sat   = sat_q;

endmodule

// File: tb/tb_clk_tick_meter.sv
// Bench for clk_tick_meter: a default-width instance and a narrow one
// (CNT_W=3, PER_W=4) share all inputs. A time-based model predicts every
// output each cycle; directed scenarios add literal expectations.
module tb_clk_tick_meter;

  localparam int N      = 2;
  localparam int MAX_A  = (1 << 24) - 1;
  localparam int MAX_B  = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic div_in = 1'b0;
  logic en = 1'b0;

  logic        rise_a, fall_a, pv_a, ps_a;
  logic [15:0] tick_a;
  logic [23:0] per_a;
  logic        rise_b, fall_b, pv_b, ps_b;
  logic [2:0]  tick_b;
  logic [3:0]  per_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clk_tick_meter dut_a (
    .clk(clk), .rst_n(rst_n), .div_in(div_in), .en(en),
    .rise_pulse(rise_a), .fall_pulse(fall_a), .tick_cnt(tick_a),
    .period(per_a), .period_valid(pv_a), .period_sat(ps_a)
  );

  clk_tick_meter #(.SYNC_STAGES(2), .CNT_W(3), .PER_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .div_in(div_in), .en(en),
    .rise_pulse(rise_b), .fall_pulse(fall_b), .tick_cnt(tick_b),
    .period(per_b), .period_valid(pv_b), .period_sat(ps_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d, want %0d", nm, $time, act, exp);
    end
  endtask

  // Model: input history per edge, enable bookkeeping and the time of the
  // last qualifying rise; period is the difference of rise edge numbers.
  logic [7:0] hist;
  bit  active;
  int  last_rise, edge_n, tick_m;
  bit  m_rise, m_fall, m_valid;
  int  m_per_a, m_per_b;
  bit  m_sat_a, m_sat_b;

  always @(posedge clk) begin
    bit din, en_s, r, f;
    int gap;
    din  = div_in;
    en_s = en;
    if (!rst_n) begin
      hist = '0; active = 0; last_rise = -1; edge_n = 0; tick_m = 0;
      m_rise = 0; m_fall = 0; m_valid = 0;
      m_per_a = 0; m_per_b = 0; m_sat_a = 0; m_sat_b = 0;
    end else begin
      edge_n++;
      hist = {hist[6:0], din};
      r = hist[N] & ~hist[N+1];
      f = ~hist[N] & hist[N+1];
      m_rise = r;
      m_fall = f;
      m_valid = 0;
      if (r && en_s) tick_m++;
      if (!en_s) begin
        active = 0;
        last_rise = -1;
      end else if (!active) begin
        active = 1;
      end else if (r) begin
        if (last_rise >= 0) begin
          gap = edge_n - last_rise;
          m_valid = 1;
          m_per_a = (gap < MAX_A) ? gap : MAX_A;
          m_sat_a = (gap >= MAX_A);
          m_per_b = (gap < MAX_B) ? gap : MAX_B;
          m_sat_b = (gap >= MAX_B);
        end
        last_rise = edge_n;
      end
    end
    #1;
    chk("rise_a", rise_a, m_rise);
    chk("fall_a", fall_a, m_fall);
    chk("tick_a", tick_a, tick_m % 65536);
    chk("valid_a", pv_a, m_valid);
    chk("period_a", per_a, m_per_a);
    chk("sat_a", ps_a, m_sat_a);
    chk("rise_b", rise_b, m_rise);
    chk("fall_b", fall_b, m_fall);
    chk("tick_b", tick_b, tick_m % 8);
    chk("valid_b", pv_b, m_valid);
    chk("period_b", per_b, m_per_b);
    chk("sat_b", ps_b, m_sat_b);
  end

  // Literal bookkeeping done from the stimulus process only.
  int nv;
  int lp_a, lp_b;
  bit ls_a, ls_b;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (pv_a) begin
        nv++;
        lp_a = per_a; ls_a = ps_a; lp_b = per_b; ls_b = ps_b;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    div_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int nv0;
    nv = 0;
    repeat (3) @(negedge clk);
    chk("rst_tick", tick_a, 0);
    chk("rst_period", per_a, 0);
    chk("rst_rise", rise_a, 0);
    chk("rst_valid", pv_a, 0);
    rst_n = 1'b1;
    en = 1'b1;

    // latency of rise and fall strobes
    step(4);
    @(posedge clk); #1 div_in = 1'b1;
    @(posedge clk); #2 chk("lat_rise_e1", rise_a, 0);
    @(posedge clk); #2 chk("lat_rise_e2", rise_a, 0);
    @(posedge clk); #2 chk("lat_rise_e3", rise_a, 1);
    chk("lat_first_tick", tick_a, 1);
    chk("lat_first_novalid", pv_a, 0);
    @(posedge clk); #2 chk("lat_rise_e4", rise_a, 0);
    #1 div_in = 1'b0;
    @(posedge clk); #2 chk("lat_fall_e1", fall_a, 0);
    @(posedge clk); #2 chk("lat_fall_e2", fall_a, 0);
    @(posedge clk); #2 chk("lat_fall_e3", fall_a, 1);
    chk("lat_fall_norise", rise_a, 0);
    @(posedge clk); #2 chk("lat_fall_e4", fall_a, 0);
    @(negedge clk);

    // 16-cycle square wave
    do_reset();
    step(3);
    for (int i = 0; i < 5; i++) begin
      div_in = 1'b1; step(8);
      div_in = 1'b0; step(8);
    end
    chk("p16_nvalid", nv, 4);
    chk("p16_period_a", lp_a, 16);
    chk("p16_sat_a", ls_a, 0);
    chk("p16_period_b", lp_b, 15);
    chk("p16_sat_b", ls_b, 1);
    chk("p16_tick_a", tick_a, 5);
    chk("p16_tick_b", tick_b, 5);

    // saturation on the narrow instance: gap 40 then gap 8
    do_reset();
    step(3);
    div_in = 1'b1; step(4);
    div_in = 1'b0; step(36);
    div_in = 1'b1; step(4);
    chk("sat_nvalid1", nv, 1);
    chk("sat_gap40_b", lp_b, 15);
    chk("sat_gap40_sb", ls_b, 1);
    chk("sat_gap40_a", lp_a, 40);
    div_in = 1'b0; step(4);
    div_in = 1'b1; step(4);
    chk("sat_nvalid2", nv, 2);
    chk("sat_gap8_b", lp_b, 8);
    chk("sat_gap8_sb", ls_b, 0);
    chk("sat_gap8_a", lp_a, 8);
    div_in = 1'b0; step(6);

    // tick counter wrap on the narrow instance
    do_reset();
    step(3);
    for (int i = 0; i < 9; i++) begin
      div_in = 1'b1; step(3);
      chk("wrap_tick_b", tick_b, (i + 1) % 8);
      div_in = 1'b0; step(3);
    end
    chk("wrap_tick_a", tick_a, 9);
    chk("wrap_period_b", lp_b, 6);
    chk("wrap_sat_b", ls_b, 0);

    // en dropped in the very cycle of a rise
    do_reset();
    step(3);
    div_in = 1'b1; step(4);
    div_in = 1'b0; step(4);
    nv0 = nv;
    div_in = 1'b1; step(2);
    en = 1'b0;
    @(posedge clk); #1;
    chk("en_drop_rise", rise_a, 1);
    chk("en_drop_novalid", pv_a, 0);
    chk("en_drop_tick", tick_a, 1);
    @(negedge clk);
    step(3);
    div_in = 1'b0; step(4);
    en = 1'b1; step(2);
    div_in = 1'b1; step(4);
    div_in = 1'b0; step(4);
    chk("reen_arm_only", nv, nv0);
    chk("reen_arm_tick", tick_a, 2);
    div_in = 1'b1; step(4);
    chk("reen_valid", nv, nv0 + 1);
    chk("reen_period", lp_a, 8);
    chk("reen_tick", tick_a, 3);

    // async reset mid-measurement, div_in held high
    step(2);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("areset_tick", tick_a, 0);
    chk("areset_period", per_a, 0);
    chk("areset_rise", rise_a, 0);
    chk("areset_valid", pv_a, 0);
    chk("areset_sat_b", ps_b, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #2 chk("rel_rise_e1", rise_a, 0);
    @(posedge clk); #2 chk("rel_rise_e2", rise_a, 0);
    @(posedge clk); #2 chk("rel_rise_e3", rise_a, 1);
    @(posedge clk); #2 chk("rel_rise_e4", rise_a, 0);
    chk("rel_tick", tick_a, 1);
    step(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
